// File: rtl/dp_pkg.sv
// Shared constants, state encoding and sizing helper for the dot-product accumulator.
package dp_pkg;

    localparam logic DP_MODE_POP = 1'b0;
    localparam logic DP_MODE_MAC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dp_state_e;

    // Smallest accumulator that holds one full beat of signed products plus a sign bit.
    function automatic int unsigned dp_min_acc_w(input int unsigned n_lanes, input int unsigned elem_w);
        return 2 * elem_w + $clog2(n_lanes) + 1;
    endfunction

endpackage

// File: rtl/dp_lane_sum.sv
// Combinational per-beat partial sum: AND-popcount (mode 0) or signed lane MAC (mode 1).
module dp_lane_sum
    import dp_pkg::*;
#(
    parameter int N_LANES = 8,
    parameter int ELEM_W  = 4,
    parameter int ACC_W   = 16
) (
    input  logic [N_LANES*ELEM_W-1:0] vec_a,
    input  logic [N_LANES*ELEM_W-1:0] vec_b,
    input  logic                      mode,
    output logic [ACC_W-1:0]          partial
);

    logic        [ELEM_W-1:0]   a_s;
    logic        [ELEM_W-1:0]   b_s;
    logic signed [2*ELEM_W-1:0] a_ext_s;
    logic signed [2*ELEM_W-1:0] b_ext_s;
    logic signed [2*ELEM_W-1:0] prod_s;

    // Sum every lane; products are sign-extended so the wrap matches two's complement.
    always_comb begin
        partial = '0;
        a_s     = '0;
        b_s     = '0;
        a_ext_s = '0;
        b_ext_s = '0;
        prod_s  = '0;
        for (int i = 0; i < N_LANES; i++) begin
            a_s = vec_a[i*ELEM_W +: ELEM_W];
            b_s = vec_b[i*ELEM_W +: ELEM_W];
            if (mode == DP_MODE_MAC) begin
                a_ext_s = {{ELEM_W{a_s[ELEM_W-1]}}, a_s};
                b_ext_s = {{ELEM_W{b_s[ELEM_W-1]}}, b_s};
                prod_s  = a_ext_s * b_ext_s;
                partial = partial + {{(ACC_W-2*ELEM_W){prod_s[2*ELEM_W-1]}}, prod_s};
            end else begin
                for (int j = 0; j < ELEM_W; j++) begin
                    partial = partial + {{(ACC_W-1){1'b0}}, a_s[j] & b_s[j]};
                end
            end
        end
    end

endmodule

// File: rtl/dot_product_acc.sv
// Streaming dot-product engine: stage-P partial register, accumulator with sticky overflow,
// and a four-state FSM that separates the input and output handshakes.
module dot_product_acc
    import dp_pkg::*;
#(
    parameter int N_LANES = 8,
    parameter int ELEM_W  = 4,
    parameter int ACC_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_LANES*ELEM_W-1:0] vec_a,
    input  logic [N_LANES*ELEM_W-1:0] vec_b,
    input  logic                      in_last,
    input  logic                      mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          result,
    output logic                      overflow
);

    dp_state_e          state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               mode_q, mode_d;
    logic               p_valid_q, p_valid_d;
    logic               p_first_q, p_first_d;
    logic [ACC_W-1:0]   p_sum_q, p_sum_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic               overflow_q, overflow_d;

    logic               accept_s;
    logic               lane_mode_s;
    logic [ACC_W-1:0]   lane_sum_s;
    logic [ACC_W-1:0]   base_s;
    logic [ACC_W:0]     wide_s;
    logic               beat_ovf_s;

    assign accept_s    = in_valid & in_ready_q;
    // The first beat is not latched yet, so it uses the live mode input.
    assign lane_mode_s = (state_q == ST_IDLE) ? mode : mode_q;

    dp_lane_sum #(
        .N_LANES (N_LANES),
        .ELEM_W  (ELEM_W),
        .ACC_W   (ACC_W)
    ) u_lane_sum (
        .vec_a   (vec_a),
        .vec_b   (vec_b),
        .mode    (lane_mode_s),
        .partial (lane_sum_s)
    );

    // Next-state, pipeline, accumulator and output-holding logic.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        p_valid_d   = accept_s;
        p_first_d   = p_first_q;
        p_sum_d     = p_sum_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        base_s      = '0;
        wide_s      = '0;
        beat_ovf_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    mode_d     = mode;
                    overflow_d = 1'b0;
                    state_d    = in_last ? ST_DRAIN : ST_ACC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (accept_s && in_last) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_ACC);

        if (accept_s) begin
            p_sum_d   = lane_sum_s;
            p_first_d = (state_q == ST_IDLE);
        end else begin
            p_sum_d   = p_sum_q;
            p_first_d = p_first_q;
        end

        if (p_valid_q) begin
            base_s = p_first_q ? '0 : acc_q;
            wide_s = {1'b0, base_s} + {1'b0, p_sum_q};
            if (mode_q == DP_MODE_POP) begin
                beat_ovf_s = wide_s[ACC_W];
            end else begin
                beat_ovf_s = (base_s[ACC_W-1] == p_sum_q[ACC_W-1]) &&
                             (wide_s[ACC_W-1] != base_s[ACC_W-1]);
            end
            acc_d = wide_s[ACC_W-1:0];
            ovf_d = (p_first_q ? 1'b0 : ovf_q) | beat_ovf_s;
        end else begin
            acc_d = acc_q;
            ovf_d = ovf_q;
        end

        // DONE is entered together with the final accumulate, so results are taken one edge later.
        if ((state_q == ST_DONE) && !out_valid_q) begin
            out_valid_d = 1'b1;
            result_d    = acc_q;
            overflow_d  = ovf_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            mode_q      <= DP_MODE_POP;
            p_valid_q   <= 1'b0;
            p_first_q   <= 1'b0;
            p_sum_q     <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            mode_q      <= mode_d;
            p_valid_q   <= p_valid_d;
            p_first_q   <= p_first_d;
            p_sum_q     <= p_sum_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;

endmodule
